uart_baud_cfg: RTL and testbench
================================

Name: uart_baud_cfg

Overview:
Configuration controller for the UART baud-rate generator. It owns the generator's DVSR input and changes it in two ways: an explicit divisor write over a valid/ready handshake, or an auto-baud measurement of the start-bit width on the RX line. Every new divisor is applied only at a generator TICK boundary, so no tick period is ever corrupted. It sits between the host/config logic and the baud-rate generator, which feeds the UART TX/RX.

Parameters:
DVSR_W, 6, width of the divisor bus to the generator.
RESET_DVSR, 53, divisor driven out of reset.
CNT_W, 11, width of the auto-baud pulse-width counter (saturating).
SYNC_STAGES, 2, flip-flop stages in the i_RX synchronizer.

Ports:
i_CLK  in  1  system clock, all logic on rising edge.
i_RST_n  in  1  asynchronous active-low reset.
i_TICK  in  1  one-cycle tick from the baud-rate generator.
i_RX  in  1  raw UART RX line, asynchronous, idle high.
cfg_valid  in  1  divisor write request.
cfg_dvsr  in  DVSR_W  divisor to write.
cfg_ready  out  1  write accepted when cfg_valid & cfg_ready.
ab_start  in  1  one-cycle pulse that starts auto-baud.
ab_busy  out  1  auto-baud in progress.
ab_done  out  1  one-cycle pulse: auto-baud succeeded, divisor applied.
ab_err  out  1  one-cycle pulse: auto-baud failed, divisor unchanged.
DVSR  out  DVSR_W  divisor driven to the generator.
pend  out  1  a divisor is waiting for a TICK boundary.

Behaviour:
- Reset (async assert, sync release) sets DVSR=RESET_DVSR, state IDLE, the pending register clear, pend=0, ab_busy=0, ab_done=0, ab_err=0, cfg_ready=1, the counter at 0, and the synchronizer at all 1s.
- Generator contract: TICK period is DVSR+1 clocks. The generator is a 16x oversampler, so bit width = 16*(DVSR+1) clocks.
- i_RX passes through a SYNC_STAGES synchronizer. rx_s is the synchronized value, so measurement latency is 2 cycles.
- Top-level states:
  - IDLE: cfg_ready=1.
  - PEND: cfg_ready=0, pend=1.
  - AB_IDLE: wait for rx_s=1.
  - AB_FALL: wait for rx_s=0.
  - AB_MEAS: count cycles while rx_s=0.
  - AB_CALC: one cycle.
- IDLE transitions:
  - A cfg handshake latches cfg_dvsr into the pending register and moves to PEND.
  - ab_start moves to AB_IDLE.
  - If both occur in the same cycle, the cfg write wins and ab_start is dropped.
- PEND: on the first cycle with i_TICK=1, DVSR takes the pending value at that clock edge and the state returns to IDLE. ab_start is ignored in PEND.
- An in-PEND write of a value equal to the current DVSR still waits for a tick; there is no shortcut.
- Auto-baud, ab_busy=1 in AB_IDLE/AB_FALL/AB_MEAS/AB_CALC, cfg_ready=0 throughout:
  - AB_IDLE: when rx_s=1, go to AB_FALL.
  - AB_FALL: when rx_s=0, set W=1 and go to AB_MEAS.
  - AB_MEAS: W increments each cycle rx_s=0 and saturates at 2^CNT_W-1. If W saturates, pulse ab_err and go to IDLE. On rx_s=1, go to AB_CALC.
- AB_CALC:
  - N=(W+8)>>4, computed at CNT_W+1 bits.
  - If N==0 or N>2^DVSR_W, pulse ab_err for 1 cycle and go to IDLE with DVSR unchanged.
  - Otherwise pending=N-1, pulse ab_done, and go to PEND. ab_done asserts in the AB_CALC→PEND cycle, before the tick apply.
- ab_start while ab_busy is ignored.
- There is no abort input. A reset mid-measurement or mid-PEND discards everything and DVSR returns to RESET_DVSR.
- DVSR changes only on a clock edge where state=PEND and i_TICK=1. It never changes otherwise.

Test Plan:
- Reset: hold i_RST_n=0 for 13 ns, then release, with a 10 ns clock → DVSR=53, cfg_ready=1, ab_busy=0, pend=0. Assert i_RST_n mid-cycle and check the outputs reset immediately (asynchronous).
- Write: cfg_dvsr=10 with cfg_valid for 1 cycle → pend=1 and cfg_ready=0 until the next i_TICK. DVSR=10 on the edge of that tick. A second write while pend=1 is not accepted.
- Auto-baud OK: RX high for 20 cycles, then low for 416 cycles, then high → ab_done pulse, and after the next tick DVSR=25. Repeat with a 1024-cycle low pulse → DVSR=63.
- Auto-baud range error: a 5-cycle low pulse gives N=0 → ab_err, and DVSR keeps its old value. A 1100-cycle low pulse gives N=69 → ab_err. RX held low gives W saturating at 2047 → ab_err.
- Collision: ab_start and a cfg handshake in the same cycle → cfg wins and ab_busy stays 0. Also check that ab_start during PEND is ignored.
- Reset mid-measurement: assert i_RST_n=0 during AB_MEAS → ab_busy=0 and DVSR=53, with no ab_done or ab_err afterwards.

Source files
------------

// File: rtl/uart_baud_cfg.sv
// Divisor configuration for the UART baud-rate generator: host writes or auto-baud
// start-bit measurement, with every new divisor applied only on a generator tick.
module uart_baud_cfg #(
  parameter int DVSR_W      = 6,
  parameter int RESET_DVSR  = 53,
  parameter int CNT_W       = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_CLK,
  input  logic              i_RST_n,
  input  logic              i_TICK,
  input  logic              i_RX,
  input  logic              cfg_valid,
  input  logic [DVSR_W-1:0] cfg_dvsr,
  output logic              cfg_ready,
  input  logic              ab_start,
  output logic              ab_busy,
  output logic              ab_done,
  output logic              ab_err,
  output logic [DVSR_W-1:0] DVSR,
  output logic              pend
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PEND    = 3'd1;
  localparam logic [2:0] ST_AB_IDLE = 3'd2;
  localparam logic [2:0] ST_AB_FALL = 3'd3;
  localparam logic [2:0] ST_AB_MEAS = 3'd4;
  localparam logic [2:0] ST_AB_CALC = 3'd5;

  localparam logic [CNT_W-1:0] W_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   N_MAX = (CNT_W+1)'(2 ** DVSR_W);

  logic [1:0]             rst_sync;
  logic                   rst_n;
  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   rx_s;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  w_q, w_d;
  logic [DVSR_W-1:0] pend_q, pend_d;
  logic [DVSR_W-1:0] dvsr_q, dvsr_d;
  logic [CNT_W:0]    n;

  // Asynchronous assertion, release synchronized to i_CLK.
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge i_CLK or negedge rst_n) begin
    if (!rst_n) rx_sync <= {SYNC_STAGES{1'b1}};
    else        rx_sync <= {rx_sync[SYNC_STAGES-2:0], i_RX};
  end
  assign rx_s = rx_sync[SYNC_STAGES-1];

  // Round the measured bit width to the nearest multiple of 16 clocks.
  assign n = ({1'b0, w_q} + (CNT_W+1)'(8)) >> 4;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    pend_d  = pend_q;
    dvsr_d  = dvsr_q;
    ab_done = 1'b0;
    ab_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          pend_d  = cfg_dvsr;
          state_d = ST_PEND;
        end else if (ab_start) begin
          state_d = ST_AB_IDLE;
        end
      end
      ST_PEND: begin
        if (i_TICK) begin
          dvsr_d  = pend_q;
          state_d = ST_IDLE;
        end
      end
      ST_AB_IDLE: if (rx_s) state_d = ST_AB_FALL;
      ST_AB_FALL: begin
        if (!rx_s) begin
          w_d     = CNT_W'(1);
          state_d = ST_AB_MEAS;
        end
      end
      ST_AB_MEAS: begin
        if (rx_s) begin
          state_d = ST_AB_CALC;
        end else if (w_q == W_MAX) begin
          ab_err  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          w_d = w_q + CNT_W'(1);
        end
      end
      ST_AB_CALC: begin
        if (n == '0 || n > N_MAX) begin
          ab_err  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          pend_d  = DVSR_W'(n - (CNT_W+1)'(1));
          ab_done = 1'b1;
          state_d = ST_PEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      pend_q  <= '0;
      dvsr_q  <= DVSR_W'(RESET_DVSR);
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      pend_q  <= pend_d;
      dvsr_q  <= dvsr_d;
    end
  end

  assign cfg_ready = (state_q == ST_IDLE);
  assign pend      = (state_q == ST_PEND);
  assign ab_busy   = (state_q == ST_AB_IDLE) || (state_q == ST_AB_FALL) ||
                     (state_q == ST_AB_MEAS) || (state_q == ST_AB_CALC);
  assign DVSR      = dvsr_q;

endmodule

// File: tb/tb_uart_baud_cfg.sv
// Directed bench for uart_baud_cfg: reset, host writes, auto-baud success/errors,
// collisions and asynchronous reset during a measurement.
module tb_uart_baud_cfg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       rx;
  logic       cfg_valid;
  logic [5:0] cfg_dvsr;
  logic       cfg_ready;
  logic       ab_start;
  logic       ab_busy;
  logic       ab_done;
  logic       ab_err;
  logic [5:0] dvsr;
  logic       pend;

  int total = 0;
  int bad   = 0;

  logic got_busy, got_done, got_err;

  always #5 clk = ~clk;

  uart_baud_cfg dut (
    .i_CLK     (clk),
    .i_RST_n   (rst_n),
    .i_TICK    (tick),
    .i_RX      (rx),
    .cfg_valid (cfg_valid),
    .cfg_dvsr  (cfg_dvsr),
    .cfg_ready (cfg_ready),
    .ab_start  (ab_start),
    .ab_busy   (ab_busy),
    .ab_done   (ab_done),
    .ab_err    (ab_err),
    .DVSR      (dvsr),
    .pend      (pend)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // Start auto-baud, idle high 20 cycles, drive a low pulse, then watch for the result.
  task automatic run_ab(input int low_len, output logic busy, output logic done,
                        output logic err);
    done     = 1'b0;
    err      = 1'b0;
    ab_start = 1'b1;
    step();
    ab_start = 1'b0;
    busy     = ab_busy;
    for (int i = 0; i < 20; i++) step();
    rx = 1'b0;
    for (int i = 0; i < low_len; i++) begin
      step();
      if (ab_done) done = 1'b1;
      if (ab_err)  err  = 1'b1;
    end
    rx = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ab_done) done = 1'b1;
      if (ab_err)  err  = 1'b1;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    tick      = 1'b0;
    rx        = 1'b1;
    cfg_valid = 1'b0;
    cfg_dvsr  = '0;
    ab_start  = 1'b0;
    #13;
    rst_n = 1'b1;
    check("rst_dvsr", 32'(dvsr), 53);
    check("rst_ready", 32'(cfg_ready), 1);
    check("rst_busy", 32'(ab_busy), 0);
    check("rst_pend", 32'(pend), 0);
    for (int i = 0; i < 3; i++) step();

    // Host write waits for a tick; second write and ab_start are refused in PEND.
    cfg_valid = 1'b1;
    cfg_dvsr  = 6'd10;
    check("wr_ready_before", 32'(cfg_ready), 1);
    step();
    cfg_valid = 1'b0;
    check("wr_pend", 32'(pend), 1);
    check("wr_ready_pend", 32'(cfg_ready), 0);
    check("wr_dvsr_hold", 32'(dvsr), 53);
    cfg_valid = 1'b1;
    cfg_dvsr  = 6'd20;
    step();
    cfg_valid = 1'b0;
    ab_start  = 1'b1;
    step();
    ab_start  = 1'b0;
    check("wr2_pend", 32'(pend), 1);
    check("pend_ab_ignored", 32'(ab_busy), 0);
    check("wr2_dvsr_hold", 32'(dvsr), 53);
    do_tick();
    check("wr_dvsr_applied", 32'(dvsr), 10);
    check("wr_pend_clear", 32'(pend), 0);
    check("wr_ready_back", 32'(cfg_ready), 1);
    step();
    check("wr_second_dropped", 32'(dvsr), 10);

    // 416-cycle low: N=(416+8)>>4=26 -> DVSR 25.
    run_ab(416, got_busy, got_done, got_err);
    check("ab416_busy", 32'(got_busy), 1);
    check("ab416_done", 32'(got_done), 1);
    check("ab416_err", 32'(got_err), 0);
    check("ab416_pend", 32'(pend), 1);
    check("ab416_dvsr_hold", 32'(dvsr), 10);
    do_tick();
    check("ab416_dvsr", 32'(dvsr), 25);

    // 1024-cycle low: N=64, the largest legal value -> DVSR 63.
    run_ab(1024, got_busy, got_done, got_err);
    check("ab1024_done", 32'(got_done), 1);
    do_tick();
    check("ab1024_dvsr", 32'(dvsr), 63);

    // 5-cycle low: N=0 -> error.
    run_ab(5, got_busy, got_done, got_err);
    check("ab5_err", 32'(got_err), 1);
    check("ab5_done", 32'(got_done), 0);
    check("ab5_dvsr", 32'(dvsr), 63);
    check("ab5_idle", 32'(cfg_ready), 1);

    // 1100-cycle low: N=69 > 64 -> error.
    run_ab(1100, got_busy, got_done, got_err);
    check("ab1100_err", 32'(got_err), 1);
    check("ab1100_done", 32'(got_done), 0);
    check("ab1100_dvsr", 32'(dvsr), 63);

    // Line stuck low: counter saturates -> error.
    run_ab(2200, got_busy, got_done, got_err);
    check("absat_err", 32'(got_err), 1);
    check("absat_done", 32'(got_done), 0);
    check("absat_dvsr", 32'(dvsr), 63);

    // Collision: cfg write wins over ab_start.
    cfg_valid = 1'b1;
    cfg_dvsr  = 6'd7;
    ab_start  = 1'b1;
    step();
    cfg_valid = 1'b0;
    ab_start  = 1'b0;
    check("coll_busy", 32'(ab_busy), 0);
    check("coll_pend", 32'(pend), 1);
    do_tick();
    check("coll_dvsr", 32'(dvsr), 7);

    // Asynchronous reset mid-measurement.
    ab_start = 1'b1;
    step();
    ab_start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rx = 1'b0;
    for (int i = 0; i < 30; i++) step();
    check("mid_busy", 32'(ab_busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(ab_busy), 0);
    check("mid_rst_dvsr", 32'(dvsr), 53);
    check("mid_rst_ready", 32'(cfg_ready), 1);
    #4;
    rst_n = 1'b1;
    rx    = 1'b1;
    got_done = 1'b0;
    got_err  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ab_done) got_done = 1'b1;
      if (ab_err)  got_err  = 1'b1;
    end
    check("post_rst_done", 32'(got_done), 0);
    check("post_rst_err", 32'(got_err), 0);
    check("post_rst_dvsr", 32'(dvsr), 53);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
